// File: rtl/stack_dump.sv
// Stack dump reader: snapshots the stack pointer on request and walks the
// stack memory from top-of-stack downward through a dedicated synchronous
// read port, streaming each entry out on a valid/ready handshake.
// Optional feature macro: STACK_DUMP_INDEX_EN adds the out_index_o port
// carrying the depth index of the entry on out_data_o.
module stack_dump #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PTR_BITS = 5
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [PTR_BITS-1:0] sp_in_i,
    input  logic [PTR_BITS:0]   count_i,
    output logic [PTR_BITS-1:0] mem_addr_o,
    input  logic [WIDTH-1:0]    mem_rd_i,
    output logic [WIDTH-1:0]    out_data_o,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                out_last_o,
    output logic                busy_o,
    output logic                done_o
`ifdef STACK_DUMP_INDEX_EN
    ,
    output logic [PTR_BITS:0]   out_index_o
`endif
);

    typedef enum logic [1:0] {StIdle, StRd, StWait, StOut} state_e;

    // Full memory depth expressed in the count width (2**PTR_BITS).
    localparam logic [PTR_BITS:0]   DepthCnt = {1'b1, {PTR_BITS{1'b0}}};
    localparam logic [PTR_BITS:0]   IdxOne   = {{PTR_BITS{1'b0}}, 1'b1};
    localparam logic [PTR_BITS-1:0] AddrOne  = {{(PTR_BITS-1){1'b0}}, 1'b1};

    state_e                state_q;
    logic [PTR_BITS-1:0]   base_q;
    logic [PTR_BITS:0]     n_q;
    logic [PTR_BITS:0]     index_q;
    logic [PTR_BITS-1:0]   mem_addr_q;
    logic [WIDTH-1:0]      out_data_q;
    logic                  out_valid_q;
    logic                  out_last_q;
    logic                  done_q;

    logic [PTR_BITS:0]     count_clamped;
    logic [PTR_BITS:0]     last_idx;
    logic [PTR_BITS-1:0]   next_addr;

    // Requests deeper than the memory would only revisit entries, so clamp.
    assign count_clamped = (count_i > DepthCnt) ? DepthCnt : count_i;
    assign last_idx      = n_q - IdxOne;
    // Entry k lives at base-k; wraps below address 0 by natural truncation.
    assign next_addr     = base_q - index_q[PTR_BITS-1:0] - AddrOne;

    // Dump sequencer: all outputs are registered inside this one process.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            base_q      <= '0;
            n_q         <= '0;
            index_q     <= '0;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        if (count_i == '0) begin
                            // Empty dump completes at once with nothing streamed.
                            done_q <= 1'b1;
                        end else begin
                            base_q     <= sp_in_i;
                            n_q        <= count_clamped;
                            index_q    <= '0;
                            mem_addr_q <= sp_in_i;
                            state_q    <= StRd;
                        end
                    end
                end
                StRd: begin
                    // BRAM samples mem_addr on this edge.
                    state_q <= StWait;
                end
                StWait: begin
                    out_data_q  <= mem_rd_i;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (index_q == last_idx);
                    state_q     <= StOut;
                end
                StOut: begin
                    if (out_ready_i) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        if (index_q == last_idx) begin
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            index_q    <= index_q + IdxOne;
                            mem_addr_q <= next_addr;
                            state_q    <= StRd;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mem_addr_o  = mem_addr_q;
    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign done_o      = done_q;
    assign busy_o      = (state_q != StIdle);

`ifdef STACK_DUMP_INDEX_EN
    // Index only advances on a handshake, so it is stable alongside out_data.
    assign out_index_o = index_q;
`endif

endmodule

// File: tb/tb_stack_dump.sv
// Self-checking bench for stack_dump: directed cases plus randomized dumps
// compared against a queue of expected entries built from the memory image.
module tb_stack_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  sp_in;
    logic [5:0]  count;
    logic [4:0]  mem_addr;
    logic [15:0] mem_rd;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
    logic        done;
`ifdef STACK_DUMP_INDEX_EN
    logic [5:0]  out_index;
`endif

    logic [15:0] mem [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    stack_dump #(
        .WIDTH    (16),
        .PTR_BITS (5)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .sp_in_i     (sp_in),
        .count_i     (count),
        .mem_addr_o  (mem_addr),
        .mem_rd_i    (mem_rd),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_last_o  (out_last),
        .busy_o      (busy),
        .done_o      (done)
`ifdef STACK_DUMP_INDEX_EN
        ,
        .out_index_o (out_index)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read stack memory port.
    always @(posedge clk) mem_rd <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_addr"}, 32'(mem_addr), 0);
        check_eq({tag, "_data"}, 32'(out_data), 0);
        check_eq({tag, "_valid"}, 32'(out_valid), 0);
        check_eq({tag, "_last"}, 32'(out_last), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
        check_eq({tag, "_done"}, 32'(done), 0);
`ifdef STACK_DUMP_INDEX_EN
        check_eq({tag, "_index"}, 32'(out_index), 0);
`endif
    endtask

    // One complete dump. stall_entry/stall_len hold out_ready low while that
    // entry is presented, pulsing start with bogus arguments meanwhile.
    task automatic run_dump(input int sp, input int cnt, input int stall_entry,
                            input int stall_len, input bit rand_ready, input bit chk_lat);
        logic [15:0] exp_q[$];
        logic [15:0] held_data;
        logic        held_last;
        int          n, got, edges, stall_left, budget;
        bit          seen_valid, prev_held, hs, rdy;

        n = (cnt > 32) ? 32 : cnt;
        for (int k = 0; k < n; k++) exp_q.push_back(mem[(sp - k) & 31]);

        sp_in     = sp[4:0];
        count     = cnt[5:0];
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;

        if (n == 0) begin
            check_eq("empty_done", 32'(done), 1);
            check_eq("empty_busy", 32'(busy), 0);
            check_eq("empty_valid", 32'(out_valid), 0);
            step();
            check_eq("empty_done_clr", 32'(done), 0);
            check_eq("empty_valid2", 32'(out_valid), 0);
            return;
        end

        check_eq("busy_after_start", 32'(busy), 1);
        got        = 0;
        edges      = 0;
        stall_left = stall_len;
        seen_valid = 1'b0;
        prev_held  = 1'b0;
        held_data  = '0;
        held_last  = 1'b0;
        budget     = n * 24 + stall_len + 16;

        while (got < n && budget > 0) begin
            if (out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    // Valid appears on the third edge counting the accepting one.
                    if (chk_lat) check_eq("latency", 32'(edges), 2);
                end
                if (prev_held) begin
                    check_eq("hold_data", 32'(out_data), 32'(held_data));
                    check_eq("hold_last", 32'(out_last), 32'(held_last));
                end
                check_eq("data", 32'(out_data), 32'(exp_q[got]));
                check_eq("last", 32'(out_last), 32'(got == n - 1));
`ifdef STACK_DUMP_INDEX_EN
                check_eq("index", 32'(out_index), 32'(got));
`endif
            end
            if (got == stall_entry && stall_left > 0 && out_valid) begin
                rdy = 1'b0;
                stall_left--;
                start = 1'b1;
                sp_in = ~sp[4:0];
                count = 6'd7;
            end else begin
                rdy   = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                start = 1'b0;
            end
            out_ready = rdy;
            hs        = out_valid && rdy;
            prev_held = out_valid && !rdy;
            held_data = out_data;
            held_last = out_last;
            step();
            edges++;
            budget--;
            if (hs) begin
                got++;
                if (got == n) begin
                    check_eq("done_pulse", 32'(done), 1);
                    check_eq("busy_end", 32'(busy), 0);
                    check_eq("valid_end", 32'(out_valid), 0);
                end
            end else if (got < n) begin
                check_eq("no_early_done", 32'(done), 0);
            end
        end
        start = 1'b0;
        check_eq("entry_count", 32'(got), 32'(n));
        step();
        check_eq("done_one_cycle", 32'(done), 0);
    endtask

    // Reset asserted while the second entry is in WAIT.
    task automatic reset_mid_dump();
        bit hs;
        sp_in     = 5'd10;
        count     = 6'd5;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start = 1'b0;
        hs    = 1'b0;
        for (int i = 0; i < 12 && !hs; i++) begin
            hs = out_valid;
            step();
        end
        check_eq("rst_first_hs", 32'(hs), 1);
        step();
        check_eq("rst_pre_busy", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        check_all_zero("rst_held");
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("rst_no_done", 32'(done), 0);
            check_eq("rst_no_resume", 32'(busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        sp_in     = '0;
        count     = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        step();

        run_dump(5, 3, -1, 0, 1'b0, 1'b1);
        run_dump(1, 4, -1, 0, 1'b0, 1'b0);
        run_dump(7, 0, -1, 0, 1'b0, 1'b0);
        run_dump(31, 40, -1, 0, 1'b0, 1'b0);
        run_dump(5, 3, 1, 5, 1'b0, 1'b1);
        reset_mid_dump();
        run_dump(10, 5, -1, 0, 1'b0, 1'b1);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
            run_dump(int'($urandom_range(0, 31)), int'($urandom_range(0, 40)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
